// File: rtl/fifo_sync_202.sv
// Single-clock staging FIFO for 202-bit words with registered read data.
// Flags are decoded from the registered occupancy count.
module fifo_sync_202 #(
  parameter int unsigned DATA_WIDTH = 202,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  valid
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH-1:0] rp;
  logic [CNT_W-1:0]      count;
  logic                  we;
  logic                  re;

  assign we = wr_en & ~full;
  assign re = rd_en & ~empty;

  assign full         = (count == CNT_W'(DEPTH));
  assign almost_full  = (count >= CNT_W'(DEPTH - 1));
  assign empty        = (count == CNT_W'(0));
  assign almost_empty = (count <= CNT_W'(1));

  // Storage is never cleared; reset only blocks a concurrent write.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      mem[wp] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (we) wp <= wp + ADDR_WIDTH'(1);
      if (re) rp <= rp + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (we && !re) begin
      count <= count + CNT_W'(1);
    end else if (re && !we) begin
      count <= count - CNT_W'(1);
    end
  end

  // dout holds its last value on edges without a read accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= re;
      if (re) dout <= mem[rp];
    end
  end

endmodule

// File: tb/tb_fifo_sync_202.sv
// Scoreboard bench for fifo_sync_202: stimulus pushes expected words,
// a negedge monitor pops and compares whenever valid is presented.
module tb_fifo_sync_202;

  localparam int unsigned DW    = 202;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          full;
  logic          almost_full;
  logic          empty;
  logic          almost_empty;
  logic          valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_q   [$];

  always #5 clk = ~clk;

  fifo_sync_202 #(.DATA_WIDTH(DW), .ADDR_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .dout         (dout),
    .full         (full),
    .almost_full  (almost_full),
    .empty        (empty),
    .almost_empty (almost_empty),
    .valid        (valid)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Flag vector {full, almost_full, empty, almost_empty} from model occupancy.
  task automatic check_flags(input string tag);
    int n;
    logic [3:0] req;
    n = model_q.size();
    req = {n == DEPTH, n >= DEPTH - 1, n == 0, n <= 1};
    check({tag, "_flags"}, DW'({full, almost_full, empty, almost_empty}), DW'(req));
  endtask

  // One clock of stimulus; returns whether the model accepted the write.
  task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d,
                     input string tag, output logic acc_w);
    logic acc_r;
    wr_en = w;
    rd_en = r;
    din   = d;
    acc_w = w && (model_q.size() < DEPTH);
    acc_r = r && (model_q.size() > 0);
    if (acc_r) exp_q.push_back(model_q.pop_front());
    if (acc_w) model_q.push_back(d);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, DW'(valid), DW'(acc_r));
    check_flags(tag);
  endtask

  task automatic do_reset(input int cycles);
    rst   = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = '1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    exp_q.delete();
    check("reset_valid", DW'(valid), DW'(0));
    check_flags("reset");
  endtask

  // Monitor: every valid word must match the oldest expected word.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dout_unexpected: got %0h required no valid word", dout);
      end else begin
        check("dout", dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic acc;
    int   next;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;

    do_reset(2);
    check("reset_dout", dout, DW'(0));

    // Fill 1..16, then an ignored 17th write.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, DW'(i), "fill", acc);
      if (i == 1) begin
        check("fill1_empty", DW'(empty), DW'(0));
        check("fill1_almost_empty", DW'(almost_empty), DW'(1));
      end
      if (i == 2) check("fill2_almost_empty", DW'(almost_empty), DW'(0));
      if (i == 15) check("fill15_almost_full", DW'(almost_full), DW'(1));
      if (i == 16) check("fill16_full", DW'(full), DW'(1));
    end
    cyc(1'b1, 1'b0, DW'(17), "overflow", acc);
    check("overflow_full", DW'(full), DW'(1));

    // Drain 16 words plus one read while empty.
    for (int i = 1; i <= 17; i++) cyc(1'b0, 1'b1, DW'(0), "drain", acc);
    check("drain17_valid", DW'(valid), DW'(0));
    check("drain17_dout_hold", dout, DW'(16));
    check("drain17_empty", DW'(empty), DW'(1));

    // Eight stored, then 20 simultaneous cycles across pointer wrap.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, DW'(101 + i), "pre_sim", acc);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, DW'(109 + i), "sim", acc);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, DW'(0), "post_sim", acc);

    // Flow-control idiom driven from the DUT's early flags.
    next = 1;
    for (int c = 0; c < 200; c++) begin
      cyc(~almost_full, ~almost_empty, DW'(next), "flow", acc);
      if (acc) next++;
      if (c >= 4) begin
        check("flow_no_full", DW'(full), DW'(0));
        check("flow_no_empty", DW'(empty), DW'(0));
      end
    end
    check("flow_progress", DW'(next > 150), DW'(1));
    while (model_q.size() > 0) cyc(1'b0, 1'b1, DW'(0), "flow_drain", acc);
    cyc(1'b0, 1'b0, DW'(0), "idle", acc);

    // Mid-operation reset discards stored words.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DW'(32'h500 + i), "pre_rst", acc);
    do_reset(1);
    check("midrst_empty", DW'(empty), DW'(1));
    cyc(1'b1, 1'b0, DW'(32'hABC), "post_rst_wr", acc);
    cyc(1'b0, 1'b1, DW'(0), "post_rst_rd", acc);
    check("post_rst_dout", dout, DW'(32'hABC));
    cyc(1'b0, 1'b0, DW'(0), "final", acc);

    check("scoreboard_empty", DW'(exp_q.size()), DW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
